// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator.
//
// Free-running pixel/line counters with registered sync, active-draw and new-frame strobes,
// plus a frame counter. Every flag decodes the hcount/vcount value presented on the same
// cycle, because flags and counters are computed from the same next-state values.
//
// Optional feature (macro VIDEO_TIMING_DELAY_EN): hs/vs/ad are also passed through a
// SYNC_DELAY-deep shift register, so that they line up with a downstream pixel pipeline.
// When the macro is undefined, the *_dly outputs simply mirror hs/vs/ad_out.
//
// Ports:
//   pixel_clk_in  pixel clock, rising edge
//   rst_in        asynchronous active-high reset
//   hcount_out    pixel index in line, 0..TOTAL_H-1
//   vcount_out    line index in frame, 0..TOTAL_V-1
//   hs_out        horizontal sync, active-high
//   vs_out        vertical sync, active-high
//   ad_out        active draw (pixel visible)
//   nf_out        new-frame strobe, one cycle at (ACTIVE_H, ACTIVE_V)
//   fc_out        frame counter, wraps modulo 2^FC_WIDTH
//   hs_dly_out    hs_out retimed
//   vs_dly_out    vs_out retimed
//   ad_dly_out    ad_out retimed
module video_timing_gen #(
    parameter int unsigned ACTIVE_H   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned ACTIVE_V   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter int unsigned FC_WIDTH   = 6,
    parameter int unsigned SYNC_DELAY = 4
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    output logic [10:0]         hcount_out,
    output logic [9:0]          vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_WIDTH-1:0] fc_out,
    output logic                hs_dly_out,
    output logic                vs_dly_out,
    output logic                ad_dly_out
);

    localparam int unsigned TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int unsigned TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

    // Thresholds carry one extra bit so a sync end equal to 2048/1024 still compares correctly.
    localparam logic [11:0] H_LAST   = 12'(TOTAL_H - 1);
    localparam logic [11:0] H_ACT    = 12'(ACTIVE_H);
    localparam logic [11:0] HS_START = 12'(ACTIVE_H + H_FP);
    localparam logic [11:0] HS_END   = 12'(ACTIVE_H + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(TOTAL_V - 1);
    localparam logic [10:0] V_ACT    = 11'(ACTIVE_V);
    localparam logic [10:0] VS_START = 11'(ACTIVE_V + V_FP);
    localparam logic [10:0] VS_END   = 11'(ACTIVE_V + V_FP + V_SYNC);

    if (TOTAL_H - 1 > 2047) begin : g_h_range_chk
        $error("video_timing_gen: TOTAL_H-1 exceeds 11-bit hcount");
    end
    if (TOTAL_V - 1 > 1023) begin : g_v_range_chk
        $error("video_timing_gen: TOTAL_V-1 exceeds 10-bit vcount");
    end
    if (SYNC_DELAY < 1) begin : g_delay_chk
        $error("video_timing_gen: SYNC_DELAY must be >= 1");
    end

    logic [10:0]         h_q, h_d;
    logic [9:0]          v_q, v_d;
    logic                hs_q, hs_d, vs_q, vs_d, ad_q, ad_d, nf_q, nf_d;
    logic [FC_WIDTH-1:0] fc_q, fc_d;
    logic [11:0]         h_ext;
    logic [10:0]         v_ext;

    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if ({1'b0, h_q} == H_LAST) begin
            h_d = '0;
            v_d = ({1'b0, v_q} == V_LAST) ? '0 : v_q + 10'd1;
        end
        h_ext = {1'b0, h_d};
        v_ext = {1'b0, v_d};
        ad_d  = (h_ext < H_ACT) && (v_ext < V_ACT);
        hs_d  = (h_ext >= HS_START) && (h_ext < HS_END);
        vs_d  = (v_ext >= VS_START) && (v_ext < VS_END);
        nf_d  = (h_ext == H_ACT) && (v_ext == V_ACT);
        fc_d  = nf_d ? fc_q + FC_WIDTH'(1) : fc_q;
    end

    // Reset parks the raster on its last back-porch pixel so the first edge lands on (0,0).
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            h_q  <= H_LAST[10:0];
            v_q  <= V_LAST[9:0];
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            ad_q <= 1'b0;
            nf_q <= 1'b0;
            fc_q <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            ad_q <= ad_d;
            nf_q <= nf_d;
            fc_q <= fc_d;
        end
    end

    assign hcount_out = h_q;
    assign vcount_out = v_q;
    assign hs_out     = hs_q;
    assign vs_out     = vs_q;
    assign ad_out     = ad_q;
    assign nf_out     = nf_q;
    assign fc_out     = fc_q;

`ifdef VIDEO_TIMING_DELAY_EN
    // Each stage holds {hs, vs, ad}; the last stage is the output SYNC_DELAY cycles late.
    logic [SYNC_DELAY-1:0][2:0] dly_q;
    logic [SYNC_DELAY:0][2:0]   dly_chain;

    assign dly_chain = {dly_q, {hs_q, vs_q, ad_q}};

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_chain[SYNC_DELAY-1:0];
        end
    end

    assign hs_dly_out = dly_q[SYNC_DELAY-1][2];
    assign vs_dly_out = dly_q[SYNC_DELAY-1][1];
    assign ad_dly_out = dly_q[SYNC_DELAY-1][0];
`else
    assign hs_dly_out = hs_q;
    assign vs_dly_out = vs_q;
    assign ad_dly_out = ad_q;
`endif

endmodule
